hyperbus_arbiter: RTL
=====================

# hyperbus_arbiter

Round-robin arbiter sharing the single request/response port of the HyperBus FIFO bridge (`rrq`/`wrq`, `adr`, `tx_dat`, `rx_dat`, `tx_ready`/`rx_valid`) between `NPORTS` single-word requesters in the `wb_clk` domain. Grants one transaction at a time, holds address/data stable to the bridge, and returns a one-cycle ack (or err on watchdog timeout) to the granted port. Sits between the CPU/DMA bus adapters and the bridge, replacing direct single-master hookup.

## Interface
- `NPORTS`, 2: number of requester ports (2..8).
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: request data width.
- `TIMEOUT`, 1024: cycles in WAIT before abort; 0 disables watchdog.
- `wb_clk` in 1: single clock; all logic posedge.
- `wb_rst_n` in 1: asynchronous, active-low reset.
- `req_i` in NPORTS: per-port level request, held until ack/err.
- `we_i` in NPORTS: per-port 1=write, 0=read.
- `adr_i` in NPORTS*ADDR_WIDTH: packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- `dat_i` in NPORTS*DATA_WIDTH: packed write data, same packing.
- `dat_o` out DATA_WIDTH: read data, shared, valid while ack_o of a read is high.
- `ack_o` out NPORTS: one-cycle completion pulse to granted port.
- `err_o` out NPORTS: one-cycle timeout pulse to granted port.
- `gnt_o` out NPORTS: one-hot current grant, 0 when idle.
- `busy_o` out 1: high in every state except IDLE.
- `rrq` out 1: one-cycle read request to bridge.
- `wrq` out 1: one-cycle write request to bridge.
- `adr_o` out ADDR_WIDTH: latched address to bridge.
- `tx_dat_o` out DATA_WIDTH: latched write data to bridge.
- `rx_dat_i` in DATA_WIDTH: read data from bridge.
- `tx_ready` in 1: bridge write completion.
- `rx_valid` in 1: bridge read completion, rx_dat_i valid same cycle.

## Operation
- States (one-hot): IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: if any req_i, pick winner by round robin starting at `last+1` mod NPORTS (wraps); latch we, adr, dat of winner into registers driving adr_o/tx_dat_o; set gnt_o; → ISSUE.
- ISSUE: assert rrq (read) or wrq (write) for exactly one cycle; clear timeout counter; → WAIT.
- WAIT: on matching completion (tx_ready for write, rx_valid for read) latch rx_dat_i into dat_o (reads), → RESP. Non-matching completion ignored. Counter increments each cycle; when it reaches TIMEOUT-1 with no completion: pulse err_o[g], → DRAIN. Completion in the expiry cycle wins (normal RESP).
- RESP: ack_o[g]=1 for this one cycle; `last`←g; → IDLE (gnt_o cleared). Requester drops req_i after sampling ack, so IDLE never re-issues same transaction.
- DRAIN: absorb the late completion of the aborted op: on matching completion or a second TIMEOUT cycles, → IDLE with `last`←g. No ack.
- Completions arriving in IDLE/ISSUE/RESP are ignored.
- adr_o/tx_dat_o/we held constant from ISSUE through RESP/DRAIN.

## Timing
- Reset values: state IDLE, `last`=NPORTS-1 (port 0 wins first), rrq=wrq=0, ack_o=err_o=gnt_o=0, busy_o=0, adr_o=tx_dat_o=dat_o=0, counter 0.
- req_i sampled at edge n in IDLE → rrq/wrq high cycle n+1 → WAIT from n+2.
- Completion sampled at edge k → ack_o high cycle k+1, IDLE at k+2. Minimum request-to-ack: 3 cycles.
- Back-to-back: next grant decided in IDLE cycle k+2, rrq/wrq at k+3.
- Reset asserted mid-transaction: immediate return to reset values; bridge transaction is not cancelled; its late completion lands in IDLE and is ignored.
- TIMEOUT=0: WAIT never times out, DRAIN unreachable.

## Structure
- Package `hyperbus_pkg`: state one-hot localparams, `HB_TIMEOUT_DEFAULT`, `clog2`-based counter width function.
- Sub-module `hyperbus_rr_arbiter`: combinational one-hot winner from req vector and `last` pointer; pointer register stays in top.

## Test plan
- Single read port 0, adr=0x100, rx_valid 5 cycles after rrq with rx_dat_i=0xDEADBEEF -> rrq one cycle, ack_o[0] one cycle later with dat_o=0xDEADBEEF.
- Ports 0 and 1 request continuously from reset -> grants alternate 0,1,0,1; adr_o matches granted port each time.
- Write port 1 dat=0x12345678, tx_ready asserted -> wrq one cycle, tx_dat_o=0x12345678 stable until ack_o[1].
- TIMEOUT=8, no completion -> err_o[0] pulse 8 cycles into WAIT, DRAIN; late rx_valid at cycle 12 absorbed, no ack, next request served normally.
- Completion in exact expiry cycle -> ack_o, no err_o.
- wb_rst_n low during WAIT, stray tx_ready after release -> all outputs 0, no ack, next req from port 0.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types and helpers for the HyperBus request arbiter.
// State encoding is one-hot; counter and index widths are derived from parameters.
package hyperbus_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ISSUE = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_RESP  = 5'b01000,
    ST_DRAIN = 5'b10000
  } hb_state_t;

  localparam int HB_TIMEOUT_DEFAULT = 1024;

  // Watchdog counter only has to reach TIMEOUT-1.
  function automatic int hb_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic int hb_idx_w(input int nports);
    return (nports < 2) ? 1 : $clog2(nports);
  endfunction

endpackage

// File: rtl/hyperbus_rr_arbiter.sv
// Combinational round-robin pick: the first requester after i_last (cyclic) wins.
// The pointer register itself lives in the top level.
module hyperbus_rr_arbiter
  import hyperbus_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int PW     = hb_idx_w(NPORTS)
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [PW-1:0]     i_last,
  output logic [NPORTS-1:0] o_gnt
);

  logic w_found;

  // Distance k of port p from the pointer; the smallest requesting distance wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (!w_found && i_req[p] &&
            (((p + NPORTS - 1 - int'(i_last)) % NPORTS) == k)) begin
          o_gnt[p] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one HyperBus bridge request port among NPORTS
// single-word requesters, with a watchdog that aborts and drains stuck transactions.
module hyperbus_arbiter
  import hyperbus_pkg::*;
#(
  parameter int NPORTS     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = HB_TIMEOUT_DEFAULT
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst_n,
  input  logic [NPORTS-1:0]            req_i,
  input  logic [NPORTS-1:0]            we_i,
  input  logic [NPORTS*ADDR_WIDTH-1:0] adr_i,
  input  logic [NPORTS*DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0]        dat_o,
  output logic [NPORTS-1:0]            ack_o,
  output logic [NPORTS-1:0]            err_o,
  output logic [NPORTS-1:0]            gnt_o,
  output logic                         busy_o,
  output logic                         rrq,
  output logic                         wrq,
  output logic [ADDR_WIDTH-1:0]        adr_o,
  output logic [DATA_WIDTH-1:0]        tx_dat_o,
  input  logic [DATA_WIDTH-1:0]        rx_dat_i,
  input  logic                         tx_ready,
  input  logic                         rx_valid
);

  localparam int PW    = hb_idx_w(NPORTS);
  localparam int CW    = hb_cnt_w(TIMEOUT);
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_M1[CW-1:0];

  hb_state_t               r_state;
  logic [PW-1:0]           r_last;
  logic [PW-1:0]           r_gidx;
  logic [NPORTS-1:0]       r_gnt;
  logic [NPORTS-1:0]       r_ack;
  logic [NPORTS-1:0]       r_err;
  logic                    r_we;
  logic                    r_rrq;
  logic                    r_wrq;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_txd;
  logic [DATA_WIDTH-1:0]   r_rxd;
  logic [CW-1:0]           r_cnt;

  logic [NPORTS-1:0]       w_win;
  logic [PW-1:0]           w_widx;
  logic [ADDR_WIDTH-1:0]   w_wadr;
  logic [DATA_WIDTH-1:0]   w_wdat;
  logic                    w_wwe;
  logic                    w_done;
  logic                    w_expire;

  hyperbus_rr_arbiter #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_rr (
    .i_req  (req_i),
    .i_last (r_last),
    .o_gnt  (w_win)
  );

  always_comb begin
    w_widx = '0;
    w_wadr = '0;
    w_wdat = '0;
    w_wwe  = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_win[p]) begin
        w_widx = p[PW-1:0];
        w_wadr = adr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdat = dat_i[p*DATA_WIDTH +: DATA_WIDTH];
        w_wwe  = we_i[p];
      end
    end
  end

  // Only the completion matching the latched direction counts.
  assign w_done   = r_we ? tx_ready : rx_valid;
  assign w_expire = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= PW'(NPORTS - 1);
      r_gidx  <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_we    <= 1'b0;
      r_rrq   <= 1'b0;
      r_wrq   <= 1'b0;
      r_adr   <= '0;
      r_txd   <= '0;
      r_rxd   <= '0;
      r_cnt   <= '0;
    end else begin
      r_rrq <= 1'b0;
      r_wrq <= 1'b0;
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req_i) begin
            r_gnt   <= w_win;
            r_gidx  <= w_widx;
            r_we    <= w_wwe;
            r_adr   <= w_wadr;
            r_txd   <= w_wdat;
            r_rrq   <= !w_wwe;
            r_wrq   <= w_wwe;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion in the expiry cycle still finishes normally.
          if (w_done) begin
            if (!r_we) r_rxd <= rx_dat_i;
            r_ack   <= r_gnt;
            r_state <= ST_RESP;
          end else if (w_expire) begin
            r_err   <= r_gnt;
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_last  <= r_gidx;
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          // Swallow the aborted op's late completion so it cannot hit the next grant.
          if (w_done || w_expire) begin
            r_last  <= r_gidx;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o   = (r_state != ST_IDLE);
  assign gnt_o    = r_gnt;
  assign ack_o    = r_ack;
  assign err_o    = r_err;
  assign rrq      = r_rrq;
  assign wrq      = r_wrq;
  assign adr_o    = r_adr;
  assign tx_dat_o = r_txd;
  assign dat_o    = r_rxd;

endmodule
